// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: applies one 1-bit rotate/shift step per clock
// under a start/busy/done handshake, as a low-area alternative to a barrel shifter.
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] amt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             start_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_err_q, start_err_d;

  function automatic logic [WIDTH-1:0] step(input logic [1:0] sop, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (sop)
      2'b00:   r = {d[WIDTH-2:0], d[WIDTH-1]};
      2'b01:   r = {d[WIDTH-2:0], 1'b0};
      2'b10:   r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {1'b0, d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // DONE accepts a new start exactly like IDLE so jobs can run back-to-back.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    start_err_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d    = op;
          data_d  = data_in;
          cnt_d   = amt;
          state_d = (amt == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        start_err_d = start;
        if (abort) begin
          state_d = IDLE;
        end else begin
          data_d = step(op_q, data_q);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = data_q;
  assign start_err = start_err_q;

endmodule
